// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester even/odd byte-bank arbiter.
// MEMARB_WRITE_PROTECT_EN selects the ROM write-protect behaviour (WP_EN).
package mem_arb_pkg;

   typedef enum logic {BANK_EVEN = 1'b0, BANK_ODD = 1'b1} bank_e;

   typedef struct packed {
      logic [15:0] addr;
      logic        wide;
      logic        we;
      logic [15:0] wdata;
   } acc_t;

   typedef struct packed {
      logic src;
      logic wide;
      logic swap;
   } rd_tag_t;

`ifdef MEMARB_WRITE_PROTECT_EN
   localparam logic WP_EN = 1'b1;
`else
   localparam logic WP_EN = 1'b0;
`endif

   function automatic logic [14:0] bank_idx(input logic [15:0] addr);
      return addr[15:1];
   endfunction

endpackage

// File: rtl/mem_bank_map.sv
// Combinational map of one access onto the even/odd banks: bank need, word index,
// write byte, plus the protected-write flag (active only with MEMARB_WRITE_PROTECT_EN).
module mem_bank_map
   import mem_arb_pkg::*;
#(
   parameter int          ROMSIZE = 2048,
   parameter logic [15:0] ROMBASE = 16'h4000
) (
   input  acc_t        i_acc,
   output logic        o_need_even,
   output logic        o_need_odd,
   output logic [14:0] o_idx_even,
   output logic [14:0] o_idx_odd,
   output logic [7:0]  o_byte_even,
   output logic [7:0]  o_byte_odd,
   output logic        o_prot
);

   localparam logic [16:0] ROM_LO = {1'b0, ROMBASE};
   localparam logic [16:0] ROM_HI = ROM_LO + 17'(ROMSIZE);

   logic [15:0] w_addr_b;
   logic        w_odd;
   logic        w_hit_a;
   logic        w_hit_b;
   logic [7:0]  w_byte_a;

   assign w_addr_b = i_acc.addr + 16'd1;
   assign w_odd    = i_acc.addr[0];
   // Byte A carries the high lane of a word, or the only lane of a byte access.
   assign w_byte_a = i_acc.wide ? i_acc.wdata[15:8] : i_acc.wdata[7:0];

   assign o_need_even = i_acc.wide | (w_odd == BANK_EVEN);
   assign o_need_odd  = i_acc.wide | (w_odd == BANK_ODD);
   assign o_idx_odd   = bank_idx(i_acc.addr);
   assign o_idx_even  = w_odd ? bank_idx(w_addr_b) : bank_idx(i_acc.addr);
   assign o_byte_even = w_odd ? i_acc.wdata[7:0] : w_byte_a;
   assign o_byte_odd  = w_odd ? w_byte_a : i_acc.wdata[7:0];

   assign w_hit_a = ({1'b0, i_acc.addr} >= ROM_LO) && ({1'b0, i_acc.addr} < ROM_HI);
   assign w_hit_b = ({1'b0, w_addr_b} >= ROM_LO) && ({1'b0, w_addr_b} < ROM_HI);
   assign o_prot  = WP_EN & i_acc.we & (w_hit_a | (i_acc.wide & w_hit_b));

endmodule

// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter over even/odd byte banks; same-cycle grant, read data one cycle later.
// Write protection of the ROM window is enabled by defining MEMARB_WRITE_PROTECT_EN.
module mem_bank_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          ROMSIZE = 2048,
   parameter logic [15:0] ROMBASE = 16'h4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [1:0]  wide,
   input  logic [1:0]  we,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic [1:0]  wr_err,
   output logic [14:0] read_addr_even,
   output logic [14:0] read_addr_odd,
   output logic [14:0] write_addr_even,
   output logic [14:0] write_addr_odd,
   output logic [7:0]  write_data_even,
   output logic [7:0]  write_data_odd,
   output logic        write_en_even,
   output logic        write_en_odd,
   input  logic [7:0]  read_data_even,
   input  logic [7:0]  read_data_odd
);

   acc_t        w_acc0, w_acc1;
   logic [1:0]  w_ne, w_no, w_prot, w_req, w_rd_gnt;
   logic [14:0] w_ie [2];
   logic [14:0] w_io [2];
   logic [7:0]  w_be [2];
   logic [7:0]  w_bo [2];
   logic        w_conf;
   logic        w_ev_vld, w_od_vld, w_ev_sel, w_od_sel;
   logic [15:0] w_rdata [2];

   logic        r_rr;
   logic [1:0]  r_pend;
   logic [1:0]  r_wr_err;
   rd_tag_t     r_tag [2];

   assign w_acc0 = '{addr: addr0, wide: wide[0], we: we[0], wdata: wdata0};
   assign w_acc1 = '{addr: addr1, wide: wide[1], we: we[1], wdata: wdata1};

   mem_bank_map #(.ROMSIZE(ROMSIZE), .ROMBASE(ROMBASE)) u_map0 (
      .i_acc(w_acc0), .o_need_even(w_ne[0]), .o_need_odd(w_no[0]),
      .o_idx_even(w_ie[0]), .o_idx_odd(w_io[0]),
      .o_byte_even(w_be[0]), .o_byte_odd(w_bo[0]), .o_prot(w_prot[0])
   );

   mem_bank_map #(.ROMSIZE(ROMSIZE), .ROMBASE(ROMBASE)) u_map1 (
      .i_acc(w_acc1), .o_need_even(w_ne[1]), .o_need_odd(w_no[1]),
      .o_idx_even(w_ie[1]), .o_idx_odd(w_io[1]),
      .o_byte_even(w_be[1]), .o_byte_odd(w_bo[1]), .o_prot(w_prot[1])
   );

   // Any shared bank is a conflict; r_rr names the winner, so words are all-or-nothing.
   assign w_req    = req & {2{~reset}};
   assign w_conf   = (&w_req) & ((w_ne[0] & w_ne[1]) | (w_no[0] & w_no[1]));
   assign gnt[0]   = w_req[0] & ~(w_conf & r_rr);
   assign gnt[1]   = w_req[1] & ~(w_conf & ~r_rr);
   assign w_rd_gnt = gnt & ~we;

   assign w_ev_vld = (gnt[0] & w_ne[0]) | (gnt[1] & w_ne[1]);
   assign w_od_vld = (gnt[0] & w_no[0]) | (gnt[1] & w_no[1]);
   assign w_ev_sel = ~(gnt[0] & w_ne[0]);
   assign w_od_sel = ~(gnt[0] & w_no[0]);

   always_comb begin
      read_addr_even  = '0;
      read_addr_odd   = '0;
      write_addr_even = '0;
      write_addr_odd  = '0;
      write_data_even = '0;
      write_data_odd  = '0;
      write_en_even   = 1'b0;
      write_en_odd    = 1'b0;
      if (w_ev_vld) begin
         if (we[w_ev_sel]) begin
            write_addr_even = w_ie[w_ev_sel];
            write_data_even = w_be[w_ev_sel];
            write_en_even   = ~w_prot[w_ev_sel];
         end else begin
            read_addr_even  = w_ie[w_ev_sel];
         end
      end
      if (w_od_vld) begin
         if (we[w_od_sel]) begin
            write_addr_odd = w_io[w_od_sel];
            write_data_odd = w_bo[w_od_sel];
            write_en_odd   = ~w_prot[w_od_sel];
         end else begin
            read_addr_odd  = w_io[w_od_sel];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr     <= 1'b0;
         r_pend   <= '0;
         r_wr_err <= '0;
         r_tag[0] <= '0;
         r_tag[1] <= '0;
      end else begin
         if (w_conf) r_rr <= ~r_rr;
         r_pend   <= w_rd_gnt;
         r_wr_err <= gnt & we & w_prot;
         if (w_rd_gnt[0]) r_tag[0] <= '{src: 1'b0, wide: wide[0], swap: addr0[0]};
         if (w_rd_gnt[1]) r_tag[1] <= '{src: 1'b1, wide: wide[1], swap: addr1[0]};
      end
   end

   // Odd start address swaps lanes: the first (high) byte then lives in the odd bank.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_rdata[n] = '0;
         if (r_pend[n] && (r_tag[n].src == 1'(n))) begin
            if (r_tag[n].wide)
               w_rdata[n] = r_tag[n].swap ? {read_data_odd, read_data_even}
                                          : {read_data_even, read_data_odd};
            else
               w_rdata[n] = {8'h00, r_tag[n].swap ? read_data_odd : read_data_even};
         end
      end
   end

   assign rvalid = r_pend;
   assign wr_err = r_wr_err;
   assign rdata0 = w_rdata[0];
   assign rdata1 = w_rdata[1];

endmodule
